// File: rtl/dot_product_host_pkg.sv
// Shared state encoding and batch-size helpers for the dot-product host controller.
package dot_product_host_pkg;

    localparam int DEF_NUM_VECTORS  = 8;
    localparam int DEF_VECTOR_WIDTH = 4;
    localparam int TOTAL_ELEMS      = DEF_NUM_VECTORS * DEF_VECTOR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_RD_ISSUE,
        ST_RD_CAPT,
        ST_PRESENT,
        ST_DONE
    } host_state_e;

    function automatic int total_elems(input int num_vectors, input int vector_width);
        return num_vectors * vector_width;
    endfunction

endpackage

// File: rtl/dot_product_host_ctrl.sv
// Host initiator: loads a batch into the accelerator, kicks it, reads results back as a stream.
// Optional watchdog in WAIT (adds port timeout) when DOT_PRODUCT_HOST_TIMEOUT_EN is defined.
module dot_product_host_ctrl
    import dot_product_host_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int VECTOR_WIDTH    = DEF_VECTOR_WIDTH,
    parameter int NUM_VECTORS     = DEF_NUM_VECTORS,
    parameter int ADDR_WIDTH      = 5,
    parameter int MEM3_ADDR_WIDTH = 4,
    parameter int RESULT_WIDTH    = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH),
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_a,
    input  logic [DATA_WIDTH-1:0]      in_b,
    output logic                       acc_write_en,
    output logic [ADDR_WIDTH-1:0]      acc_write_addr,
    output logic [DATA_WIDTH-1:0]      acc_data_a,
    output logic [DATA_WIDTH-1:0]      acc_data_b,
    output logic                       acc_start_reading,
    input  logic                       acc_reading_done,
    input  logic                       acc_writer_done,
    output logic                       acc_read_en,
    output logic [MEM3_ADDR_WIDTH-1:0] acc_read_addr,
    input  logic [RESULT_WIDTH-1:0]    acc_result_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RESULT_WIDTH-1:0]    res_data,
    output logic                       res_last
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
    ,
    output logic                       timeout
`endif
);

    localparam int TOTAL = total_elems(NUM_VECTORS, VECTOR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]      LAST_ELEM = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [MEM3_ADDR_WIDTH-1:0] LAST_RES  = MEM3_ADDR_WIDTH'(NUM_VECTORS - 1);

    if (TOTAL > 2**ADDR_WIDTH) begin : g_chk_addr
        $error("input memory too small for one batch");
    end
    if (NUM_VECTORS > 2**MEM3_ADDR_WIDTH) begin : g_chk_res
        $error("result memory too small for one batch");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
        $error("watchdog limit must be at least one cycle");
    end

    host_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]      elem_cnt_q, elem_cnt_d;
    logic [MEM3_ADDR_WIDTH-1:0] res_cnt_q, res_cnt_d;
    logic                       rd_seen_q, rd_seen_d;
    logic                       wr_seen_q, wr_seen_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]      data_a_q, data_a_d;
    logic [DATA_WIDTH-1:0]      data_b_q, data_b_d;
    logic                       kick_q, kick_d;
    logic                       rd_en_q, rd_en_d;
    logic [MEM3_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                       res_valid_q, res_valid_d;
    logic [RESULT_WIDTH-1:0]    res_data_q, res_data_d;
    logic                       res_last_q, res_last_d;

`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        res_cnt_d   = res_cnt_q;
        rd_seen_d   = rd_seen_q;
        wr_seen_d   = wr_seen_q;
        done_d      = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        kick_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    elem_cnt_d = '0;
                    res_cnt_d  = '0;
                    rd_seen_d  = 1'b0;
                    wr_seen_d  = 1'b0;
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = elem_cnt_q;
                    data_a_d  = in_a;
                    data_b_d  = in_b;
                    // The start pulse lands in the same cycle as the final write.
                    if (elem_cnt_q == LAST_ELEM) begin
                        kick_d  = 1'b1;
                        state_d = ST_KICK;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            ST_KICK: begin
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
                wait_cnt_d = WAIT_LOAD;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rd_seen_d = rd_seen_q | acc_reading_done;
                wr_seen_d = wr_seen_q | acc_writer_done;
                if (rd_seen_d && wr_seen_d) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = res_cnt_q;
                    state_d   = ST_RD_ISSUE;
                end
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
                else if (wait_cnt_q == '0) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
`endif
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                res_data_d  = acc_result_out;
                res_valid_d = 1'b1;
                res_last_d  = (res_cnt_q == LAST_RES);
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    if (res_cnt_q == LAST_RES) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        res_cnt_d = res_cnt_q + 1'b1;
                        rd_en_d   = 1'b1;
                        rd_addr_d = res_cnt_q + 1'b1;
                        state_d   = ST_RD_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_cnt_q  <= '0;
            res_cnt_q   <= '0;
            rd_seen_q   <= 1'b0;
            wr_seen_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            kick_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            res_cnt_q   <= res_cnt_d;
            rd_seen_q   <= rd_seen_d;
            wr_seen_q   <= wr_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            kick_q      <= kick_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign in_ready          = (state_q == ST_LOAD);
    assign busy              = busy_q;
    assign done              = done_q;
    assign acc_write_en      = wr_en_q;
    assign acc_write_addr    = wr_addr_q;
    assign acc_data_a        = data_a_q;
    assign acc_data_b        = data_b_q;
    assign acc_start_reading = kick_q;
    assign acc_read_en       = rd_en_q;
    assign acc_read_addr     = rd_addr_q;
    assign res_valid         = res_valid_q;
    assign res_data          = res_data_q;
    assign res_last          = res_last_q;
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
    assign timeout           = timeout_q;
`endif

endmodule

// File: tb/tb_dot_product_host_ctrl.sv
// Randomized directed bench for dot_product_host_ctrl with a behavioural accelerator and result model.
module tb_dot_product_host_ctrl;

    localparam int DW  = 8;
    localparam int VW  = 4;
    localparam int NV  = 8;
    localparam int AW  = 5;
    localparam int MAW = 4;
    localparam int RW  = 2*DW + $clog2(VW);
    localparam int TOT = NV*VW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          acc_write_en;
    logic [AW-1:0] acc_write_addr;
    logic [DW-1:0] acc_data_a, acc_data_b;
    logic          acc_start_reading;
    logic          acc_reading_done = 1'b0;
    logic          acc_writer_done = 1'b0;
    logic          acc_read_en;
    logic [MAW-1:0] acc_read_addr;
    logic [RW-1:0] acc_result_out = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          res_last;
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    dot_product_host_ctrl #(
        .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .NUM_VECTORS(NV),
        .ADDR_WIDTH(AW), .MEM3_ADDR_WIDTH(MAW), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .acc_write_en(acc_write_en), .acc_write_addr(acc_write_addr),
        .acc_data_a(acc_data_a), .acc_data_b(acc_data_b),
        .acc_start_reading(acc_start_reading), .acc_reading_done(acc_reading_done),
        .acc_writer_done(acc_writer_done), .acc_read_en(acc_read_en),
        .acc_read_addr(acc_read_addr), .acc_result_out(acc_result_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    int checks = 0;
    int errors = 0;
    int wr_count = 0, rd_count = 0, kick_count = 0;

    logic [DW-1:0] mem_a [TOT];
    logic [DW-1:0] mem_b [TOT];
    logic [RW-1:0] res_mem [1<<MAW];
    logic [DW-1:0] stim_a [TOT];
    logic [DW-1:0] stim_b [TOT];
    logic [RW-1:0] exp_res [NV];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accelerator side: input memories capture every write, addresses must run in order.
    always @(negedge clk) begin
        if (!rst && acc_write_en) begin
            chk("wr_addr", 64'(acc_write_addr), 64'(wr_count));
            mem_a[acc_write_addr] = acc_data_a;
            mem_b[acc_write_addr] = acc_data_b;
            wr_count++;
        end
        if (!rst && acc_read_en) begin
            chk("rd_addr", 64'(acc_read_addr), 64'(rd_count));
            rd_count++;
        end
        if (!rst && acc_start_reading) kick_count++;
    end

    always @(posedge clk) begin
        if (acc_read_en) acc_result_out <= res_mem[acc_read_addr];
    end

    task automatic chk_zero(input string tag);
        chk(tag, 64'({busy, done, in_ready, acc_write_en, acc_write_addr, acc_data_a, acc_data_b,
                      acc_start_reading, acc_read_en, acc_read_addr, res_valid, res_data, res_last}), 64'd0);
`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
`endif
    endtask

    task automatic build_stim(input bit rnd);
        int sum;
        for (int i = 0; i < TOT; i++) begin
            stim_a[i] = rnd ? DW'($urandom) : DW'(i + 1);
            stim_b[i] = rnd ? DW'($urandom) : DW'(2);
        end
        for (int k = 0; k < NV; k++) begin
            sum = 0;
            for (int j = 0; j < VW; j++) sum += int'(stim_a[k*VW+j]) * int'(stim_b[k*VW+j]);
            exp_res[k] = RW'(sum);
        end
    endtask

    task automatic start_batch();
        wr_count = 0; rd_count = 0; kick_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("in_ready_load", 64'(in_ready), 64'd1);
    endtask

    task automatic feed(input int count, input int gap_max);
        int gaps;
        for (int i = 0; i < count; i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_a = stim_a[i];
            in_b = stim_b[i];
            chk("in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_kick();
        int n = 0;
        while (!acc_start_reading && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("kick_seen", 64'(acc_start_reading), 64'd1);
    endtask

    // Accelerator completion flags, delays counted in cycles after the start pulse.
    task automatic accel_flags(input int wr_dly, input int rd_dly, input bit poke);
        int last;
        int sum;
        last = (wr_dly > rd_dly) ? wr_dly : rd_dly;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (t == 1) begin
                for (int k = 0; k < NV; k++) begin
                    sum = 0;
                    for (int j = 0; j < VW; j++) sum += int'(mem_a[k*VW+j]) * int'(mem_b[k*VW+j]);
                    res_mem[k] = RW'(sum);
                end
            end
            chk("no_early_rd", 64'(acc_read_en), 64'd0);
            if (poke) begin
                start    = (t == 1);
                in_valid = (t == 1);
                in_a     = 8'hEE;
                in_b     = 8'h11;
                if (t == 1) chk("in_ready_wait", 64'(in_ready), 64'd0);
            end
            acc_writer_done  = (t == wr_dly);
            acc_reading_done = (t == rd_dly);
        end
        @(negedge clk);
        acc_writer_done  = 1'b0;
        acc_reading_done = 1'b0;
        start            = 1'b0;
        in_valid         = 1'b0;
        chk("rd_issue_timing", 64'(acc_read_en), 64'd1);
    endtask

    task automatic consume(input int bp_max);
        int n;
        int stalls;
        for (int k = 0; k < NV; k++) begin
            n = 0;
            while (!res_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("res_valid", 64'(res_valid), 64'd1);
            chk("res_data", 64'(res_data), 64'(exp_res[k]));
            chk("res_last", 64'(res_last), 64'(k == NV-1));
            stalls = (bp_max > 0) ? int'($urandom_range(0, bp_max)) : 0;
            repeat (stalls) begin
                @(negedge clk);
                chk("hold_data", 64'(res_data), 64'(exp_res[k]));
                chk("hold_valid", 64'(res_valid), 64'd1);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("valid_drop", 64'(res_valid), 64'd0);
        end
        chk("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_clear", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic end_checks();
        chk("write_count", 64'(wr_count), 64'(TOT));
        chk("read_count", 64'(rd_count), 64'(NV));
        chk("kick_count", 64'(kick_count), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held, then released into IDLE.
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle_outputs");

        // Known batch: start with no input, then a=i+1, b=2, writer flag 5 cycles before reader flag.
        build_stim(1'b0);
        start_batch();
        repeat (3) begin
            @(negedge clk);
            chk("no_write_idle_input", 64'(acc_write_en), 64'd0);
        end
        feed(TOT, 0);
        wait_kick();
        accel_flags(3, 8, 1'b0);
        consume(0);
        end_checks();

        // Random data, input gaps, backpressure, simultaneous flags, stray start/in_valid in WAIT.
        build_stim(1'b1);
        start_batch();
        feed(TOT, 3);
        wait_kick();
        accel_flags(4, 4, 1'b1);
        consume(3);
        end_checks();

        // Reader flag already high through the kick cycle must not count.
        build_stim(1'b1);
        acc_reading_done = 1'b1;
        start_batch();
        feed(TOT, 1);
        wait_kick();
        accel_flags(2, 6, 1'b0);
        consume(2);
        end_checks();

        // Reset in the middle of LOAD, then a clean batch from address 0.
        build_stim(1'b1);
        start_batch();
        feed(10, 0);
        @(negedge clk);
        chk("partial_writes", 64'(wr_count), 64'd10);
        rst = 1'b1;
        #1;
        chk_zero("midload_reset");
        @(negedge clk);
        wr_count = 0; rd_count = 0; kick_count = 0;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("post_reset_idle");
        build_stim(1'b1);
        start_batch();
        feed(TOT, 2);
        wait_kick();
        accel_flags(1, 2, 1'b0);
        consume(1);
        end_checks();

`ifdef DOT_PRODUCT_HOST_TIMEOUT_EN
        // No completion flags: the watchdog ends the batch 16 cycles into WAIT.
        build_stim(1'b1);
        start_batch();
        chk("timeout_cleared", 64'(timeout), 64'd0);
        feed(TOT, 0);
        wait_kick();
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            chk("tmo_no_done", 64'(done), 64'd0);
            chk("tmo_no_read", 64'(acc_read_en), 64'd0);
        end
        @(negedge clk);
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_flag", 64'(timeout), 64'd1);
        chk("tmo_read_count", 64'(rd_count), 64'd0);
        @(negedge clk);
        chk("tmo_flag_held", 64'(timeout), 64'd1);
        chk("tmo_idle", 64'(busy), 64'd0);
        start_batch();
        chk("tmo_cleared_on_start", 64'(timeout), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
